mmio_uart_fifo: RTL and testbench
=================================

Name: mmio_uart_fifo

Overview:
- Parametrised memory-mapped I/O controller on the CPU MEM stage, mapped in the IO region alongside dmem.
- Adds RX and TX byte FIFOs between the core and the on-chip UART, so the core can burst bytes without polling each one.
- Provides a free-running cycle counter, a retired-instruction counter and a counter-clear register.
- Read data is registered, giving 1-cycle latency that lines up with the synchronous dmem read path into the writeback mux.

Parameters:
- RX_DEPTH, 8, RX FIFO entries; power of two, >= 2.
- TX_DEPTH, 8, TX FIFO entries; power of two, >= 2.
- CNT_WIDTH, 32, counter width; 1..32, zero-extended to 32 on read.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- addr  in  8  byte offset within IO page (ALU_out[7:0])
- rd_en  in  1  MMIO load this cycle
- wr_en  in  1  MMIO store this cycle
- wdata  in  32  store data (forwarded rs2)
- rdata  out  32  load data, valid the cycle after rd_en
- inst_retire  in  1  one instruction retired this cycle (non-bubble in WB)
- uart_tx_data  out  8  to uart data_in
- uart_tx_valid  out  1  to uart data_in_valid
- uart_tx_ready  in  1  from uart data_in_ready
- uart_rx_data  in  8  from uart data_out
- uart_rx_valid  in  1  from uart data_out_valid
- uart_rx_ready  out  1  to uart data_out_ready

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset state: both FIFOs empty; counters 0; rdata 0; uart_tx_valid 0; uart_rx_ready 1.
- Register map, read/write by addr:
  - 0x00 STATUS (R): bit0 = TX not full; bit1 = RX not empty; other bits 0 unless the optional feature is enabled.
  - 0x04 RX_DATA (R): returns {24'b0, RX head}. A read pops one entry. A read when empty returns 0 and does not pop.
  - 0x08 TX_DATA (W): pushes wdata[7:0]. A write when full is silently dropped.
  - 0x10 CYCLE (R): cycle counter.
  - 0x14 INSTRET (R): instruction counter.
  - 0x18 CNT_CLR (W): any write zeroes both counters.
- Unmapped offsets: reads return 0; writes are ignored.
- Read timing: rdata is registered. Data for the rd_en in cycle N appears in cycle N+1. With no read, rdata holds its last value.
- Side effects happen in the rd_en/wr_en cycle. rd_en and wr_en both asserted is illegal; if it occurs, wr_en wins and the read side effect is suppressed.
- RX path:
  - uart_rx_ready = RX not full.
  - A byte is accepted when uart_rx_valid && uart_rx_ready.
  - When full, ready drops and the UART holds its byte.
- TX path:
  - uart_tx_valid = TX not empty; uart_tx_data = TX head (first-word fall-through).
  - Pop on uart_tx_valid && uart_tx_ready.
- FIFO boundaries:
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - For push into a full FIFO with a simultaneous pop: RX cannot push when full (ready is low); a TX write when full is dropped even if a pop happens that cycle.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy is tracked with a log2(DEPTH)+1-bit count.
- Counters:
  - CYCLE increments every cycle.
  - INSTRET increments when inst_retire is high.
  - Both wrap modulo 2^CNT_WIDTH.
  - A CNT_CLR write takes priority over an increment in the same cycle; the value next cycle is 0.
  - A read of a counter returns its pre-update value.
- Reset mid-operation: FIFO contents are discarded; a pending uart_tx_valid drops in the cycle after rst.

Optional Feature:
- MMIO_FIFO_LEVEL_EN defined: STATUS[15:8] = RX occupancy, STATUS[23:16] = TX occupancy, each zero-extended.
- Undefined: those bits read 0 and no extra logic is generated.

Decomposition:
- Package mmio_pkg:
  - Offset constants: MMIO_STATUS, MMIO_RX_DATA, MMIO_TX_DATA, MMIO_CYCLE, MMIO_INSTRET, MMIO_CNT_CLR.
  - STATUS bit indices.
- Sub-module sync_fifo (params WIDTH, DEPTH), instantiated for RX and TX:
  - Outputs: full, empty, count, head.
  - Implements the simultaneous push/pop rules above.

Test Plan:
- Reset, then read 0x00 -> rdata = 0x0000_0001 next cycle (TX not full, RX empty); uart_rx_ready = 1; uart_tx_valid = 0.
- Write 0x41, 0x42, 0x43 to 0x08 with uart_tx_ready held 0 -> uart_tx_valid = 1, head = 0x41. Release ready -> bytes 0x41, 0x42, 0x43 are emitted in order, then valid drops.
- Write 9 bytes to 0x08 (TX_DEPTH = 8, ready low) -> STATUS bit0 goes 0 after the 8th write; the 9th byte never appears on uart_tx_data.
- Drive 8 RX bytes 0x10..0x17 -> uart_rx_ready drops after the 8th. Read 0x04 eight times -> 0x10..0x17 in order. A 9th read returns 0 and STATUS bit1 = 0.
- Run 100 cycles with inst_retire high on alternate cycles, then read 0x10 and 0x14 -> values 100 and 50 (± read-cycle offset checked exactly by the model). Write 0x18, then read 0x10 -> 1.
- CNT_WIDTH = 4: run 20 cycles after clear -> CYCLE reads 20 mod 16 = 4. With MMIO_FIFO_LEVEL_EN, after 3 RX bytes -> STATUS[15:8] = 3.

Source files
------------

// File: rtl/mmio_pkg.sv
// Register offsets and STATUS bit positions for the MMIO UART/counter block.
package mmio_pkg;

    localparam logic [7:0] MMIO_STATUS  = 8'h00;
    localparam logic [7:0] MMIO_RX_DATA = 8'h04;
    localparam logic [7:0] MMIO_TX_DATA = 8'h08;
    localparam logic [7:0] MMIO_CYCLE   = 8'h10;
    localparam logic [7:0] MMIO_INSTRET = 8'h14;
    localparam logic [7:0] MMIO_CNT_CLR = 8'h18;

    localparam int STAT_TX_NFULL   = 0;
    localparam int STAT_RX_NEMPTY  = 1;
    localparam int STAT_RX_LVL_LSB = 8;
    localparam int STAT_TX_LVL_LSB = 16;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO with an occupancy count.
// A push into a full FIFO is dropped even when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mmio_uart_fifo.sv
// MMIO controller: UART RX/TX byte FIFOs plus cycle and retired-instruction counters.
// Define MMIO_FIFO_LEVEL_EN to report FIFO occupancies in STATUS[23:8].
module mmio_uart_fifo
    import mmio_pkg::*;
#(
    parameter int RX_DEPTH  = 8,
    parameter int TX_DEPTH  = 8,
    parameter int CNT_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  addr,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        inst_retire,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);

    logic                      rx_full;
    logic                      rx_empty;
    logic [$clog2(RX_DEPTH):0] rx_count;
    logic [7:0]                rx_head;
    logic                      tx_full;
    logic                      tx_empty;
    logic [$clog2(TX_DEPTH):0] tx_count;

    logic                 rd_act;
    logic                 rx_pop;
    logic                 tx_push;
    logic                 cnt_clr;
    logic [CNT_WIDTH-1:0] cycle_cnt;
    logic [CNT_WIDTH-1:0] instret_cnt;
    logic [31:0]          status;
    logic [31:0]          rd_mux;

    // A simultaneous store wins, so the load has no side effect that cycle.
    assign rd_act  = rd_en && !wr_en;
    assign rx_pop  = rd_act && (addr == MMIO_RX_DATA);
    assign tx_push = wr_en && (addr == MMIO_TX_DATA);
    assign cnt_clr = wr_en && (addr == MMIO_CNT_CLR);

    assign uart_rx_ready = !rx_full;
    assign uart_tx_valid = !tx_empty;

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (uart_rx_valid && uart_rx_ready),
        .wdata (uart_rx_data),
        .pop   (rx_pop),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count),
        .head  (rx_head)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .wdata (wdata[7:0]),
        .pop   (uart_tx_valid && uart_tx_ready),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count),
        .head  (uart_tx_data)
    );

    always_comb begin
        status = '0;
        status[STAT_TX_NFULL]  = !tx_full;
        status[STAT_RX_NEMPTY] = !rx_empty;
`ifdef MMIO_FIFO_LEVEL_EN
        status[STAT_RX_LVL_LSB +: 8] = 8'(rx_count);
        status[STAT_TX_LVL_LSB +: 8] = 8'(tx_count);
`endif
    end

`ifdef MMIO_FIFO_LEVEL_EN
    logic unused_bits;
    assign unused_bits = ^wdata[31:8];
`else
    logic unused_bits;
    assign unused_bits = ^{wdata[31:8], rx_count, tx_count};
`endif

    always_comb begin
        rd_mux = '0;
        case (addr)
            MMIO_STATUS:  rd_mux = status;
            MMIO_RX_DATA: rd_mux = rx_empty ? 32'd0 : {24'd0, rx_head};
            MMIO_CYCLE:   rd_mux = 32'(cycle_cnt);
            MMIO_INSTRET: rd_mux = 32'(instret_cnt);
            default:      rd_mux = '0;
        endcase
    end

    // Registered read port: one-cycle latency matching the dmem path.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (rd_act) begin
            rdata <= rd_mux;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
            if (inst_retire) instret_cnt <= instret_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_mmio_uart_fifo.sv
// Directed bench for mmio_uart_fifo: register map, FIFOs, counters, 4-bit counter wrap.
module tb_mmio_uart_fifo;
    import mmio_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  addr = '0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wdata = '0;
    logic        inst_retire = 1'b0;
    logic        uart_tx_ready = 1'b0;
    logic [7:0]  uart_rx_data = '0;
    logic        uart_rx_valid = 1'b0;

    logic [31:0] rdata, rdata4;
    logic [7:0]  uart_tx_data, uart_tx_data4;
    logic        uart_tx_valid, uart_tx_valid4;
    logic        uart_rx_ready, uart_rx_ready4;

    int n_cmp = 0;
    int n_err = 0;

    mmio_uart_fifo dut (
        .clk(clk), .rst(rst), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
        .wdata(wdata), .rdata(rdata), .inst_retire(inst_retire),
        .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid),
        .uart_tx_ready(uart_tx_ready), .uart_rx_data(uart_rx_data),
        .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready)
    );

    mmio_uart_fifo #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
        .wdata(wdata), .rdata(rdata4), .inst_retire(inst_retire),
        .uart_tx_data(uart_tx_data4), .uart_tx_valid(uart_tx_valid4),
        .uart_tx_ready(uart_tx_ready), .uart_rx_data(uart_rx_data),
        .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready4)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [7:0] a);
        addr = a; rd_en = 1'b1;
        tick();
        rd_en = 1'b0; addr = '0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr_en = 1'b1;
        tick();
        wr_en = 1'b0; addr = '0; wdata = '0;
    endtask

    function automatic logic [31:0] exp_status(input logic tx_nf, input logic rx_ne,
                                               input logic [7:0] rx_lvl, input logic [7:0] tx_lvl);
        logic [31:0] s;
        s = {30'd0, rx_ne, tx_nf};
`ifdef MMIO_FIFO_LEVEL_EN
        s[15:8]  = rx_lvl;
        s[23:16] = tx_lvl;
`else
        s = s | (32'd0 & {16'd0, tx_lvl, rx_lvl});
`endif
        return s;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        tick(); tick();
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_tx_valid", {31'd0, uart_tx_valid}, 32'd0);
        chk("reset_rx_ready", {31'd0, uart_rx_ready}, 32'd1);
        rst = 1'b0;
        rd(MMIO_STATUS);
        chk("status_idle", rdata, exp_status(1, 0, 0, 0));

        // Unmapped offsets and rdata hold
        rd(8'h0C);
        chk("unmapped_rd_0c", rdata, 32'd0);
        wr(8'h0C, 32'hFFFF_FFFF);
        rd(MMIO_STATUS);
        chk("status_after_unmapped_wr", rdata, exp_status(1, 0, 0, 0));
        tick();
        chk("rdata_hold", rdata, exp_status(1, 0, 0, 0));
        rd(8'h20);
        chk("unmapped_rd_20", rdata, 32'd0);

        // TX burst with UART stalled, then drain
        wr(MMIO_TX_DATA, 32'hAAAA_AA41);
        wr(MMIO_TX_DATA, 32'h0000_0042);
        wr(MMIO_TX_DATA, 32'h0000_0043);
        chk("tx_valid_3", {31'd0, uart_tx_valid}, 32'd1);
        chk("tx_head_41", {24'd0, uart_tx_data}, 32'h41);
        rd(MMIO_STATUS);
        chk("status_tx3", rdata, exp_status(1, 0, 0, 3));
        uart_tx_ready = 1'b1;
        chk("tx_out_41", {24'd0, uart_tx_data}, 32'h41);
        tick();
        chk("tx_out_42", {24'd0, uart_tx_data}, 32'h42);
        tick();
        chk("tx_out_43", {24'd0, uart_tx_data}, 32'h43);
        tick();
        chk("tx_drained", {31'd0, uart_tx_valid}, 32'd0);
        uart_tx_ready = 1'b0;

        // TX full: 9th write dropped
        for (int i = 0; i < 8; i++) wr(MMIO_TX_DATA, 32'h50 + i);
        rd(MMIO_STATUS);
        chk("status_tx_full", rdata, exp_status(0, 0, 0, 8));
        wr(MMIO_TX_DATA, 32'h58);
        uart_tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("tx_full_valid", {31'd0, uart_tx_valid}, 32'd1);
            chk("tx_full_order", {24'd0, uart_tx_data}, 32'h50 + i);
            tick();
        end
        chk("tx_9th_dropped", {31'd0, uart_tx_valid}, 32'd0);
        uart_tx_ready = 1'b0;

        // RX fill to full
        uart_rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            uart_rx_data = 8'h10 + 8'(i);
            chk("rx_ready_fill", {31'd0, uart_rx_ready}, 32'd1);
            tick();
        end
        chk("rx_ready_full", {31'd0, uart_rx_ready}, 32'd0);
        uart_rx_data = 8'h99;
        tick();
        uart_rx_valid = 1'b0;
        chk("rx_ready_hold", {31'd0, uart_rx_ready}, 32'd0);
        rd(MMIO_STATUS);
        chk("status_rx_full", rdata, exp_status(1, 1, 8, 0));

        // Illegal rd+wr on RX_DATA: no pop
        addr = MMIO_RX_DATA; rd_en = 1'b1; wr_en = 1'b1;
        tick();
        rd_en = 1'b0; wr_en = 1'b0; addr = '0;
        rd(MMIO_STATUS);
        chk("status_no_pop", rdata, exp_status(1, 1, 8, 0));

        // RX drain in order, then empty read
        for (int i = 0; i < 8; i++) begin
            rd(MMIO_RX_DATA);
            chk("rx_order", rdata, 32'h10 + i);
            if (i == 0) chk("rx_ready_after_pop", {31'd0, uart_rx_ready}, 32'd1);
        end
        rd(MMIO_RX_DATA);
        chk("rx_empty_read", rdata, 32'd0);
        rd(MMIO_STATUS);
        chk("status_rx_empty", rdata, exp_status(1, 0, 0, 0));

        // Three RX bytes: occupancy level
        uart_rx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            uart_rx_data = 8'h21 + 8'(i);
            tick();
        end
        uart_rx_valid = 1'b0;
        rd(MMIO_STATUS);
        chk("status_rx3", rdata, exp_status(1, 1, 3, 0));
        for (int i = 0; i < 3; i++) begin
            rd(MMIO_RX_DATA);
            chk("rx3_order", rdata, 32'h21 + i);
        end

        // Clear beats increment; reads return pre-update value
        inst_retire = 1'b1;
        wr(MMIO_CNT_CLR, 32'd0);
        inst_retire = 1'b0;
        rd(MMIO_INSTRET);
        chk("instret_after_clr", rdata, 32'd0);
        rd(MMIO_CYCLE);
        chk("cycle_after_clr", rdata, 32'd1);
        chk("cycle4_after_clr", rdata4, 32'd1);

        // 100 cycles, retire on alternate cycles
        wr(MMIO_CNT_CLR, 32'h1234);
        for (int i = 0; i < 100; i++) begin
            inst_retire = (i % 2 == 0);
            tick();
        end
        inst_retire = 1'b0;
        rd(MMIO_CYCLE);
        chk("cycle_100", rdata, 32'd100);
        chk("cycle4_100", rdata4, 32'd4);
        rd(MMIO_INSTRET);
        chk("instret_50", rdata, 32'd50);
        chk("instret4_50", rdata4, 32'd2);

        // 4-bit counter wrap
        wr(MMIO_CNT_CLR, 32'd0);
        repeat (20) tick();
        rd(MMIO_CYCLE);
        chk("cycle_20", rdata, 32'd20);
        chk("cycle4_wrap", rdata4, 32'd4);

        // Reset mid-operation
        wr(MMIO_TX_DATA, 32'h61);
        wr(MMIO_TX_DATA, 32'h62);
        uart_rx_valid = 1'b1; uart_rx_data = 8'h71;
        tick(); tick();
        uart_rx_valid = 1'b0;
        rd(MMIO_STATUS);
        chk("status_pre_rst", rdata, exp_status(1, 1, 2, 2));
        chk("tx_valid_pre_rst", {31'd0, uart_tx_valid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_tx_valid", {31'd0, uart_tx_valid}, 32'd0);
        chk("rst_rx_ready", {31'd0, uart_rx_ready}, 32'd1);
        chk("rst_rdata", rdata, 32'd0);
        rd(MMIO_STATUS);
        chk("status_post_rst", rdata, exp_status(1, 0, 0, 0));
        rd(MMIO_RX_DATA);
        chk("rx_post_rst", rdata, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
